// File: rtl/stream_multiplexer.sv
// N:1 streaming mux, fixed-select or round-robin, registered output stage.
// Latency: one cycle from input transfer to out_valid/out_data.
// Backpressure: in_ready follows load = !out_valid || out_ready; a stalled output holds its word.
module stream_multiplexer #(
  parameter int WIDTH = 64,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);

  logic             load;
  logic             found;
  logic             xfer;
  logic [SEL_W-1:0] chosen;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] ch_data [N];

  // Unpack the flattened channel bus into per-channel words.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Pick the candidate channel: sel in fixed mode, first valid from ptr in round-robin.
  always_comb begin : choose_blk
    int idx;
    idx    = 0;
    found  = 1'b0;
    chosen = '0;
    if (!mode) begin
      // An out-of-range sel (possible when N is not a power of two) selects nothing.
      if (int'(sel) < N) begin
        found  = 1'b1;
        chosen = sel;
      end
    end else begin
      for (int off = 0; off < N; off++) begin
        idx = int'(ptr) + off;
        if (idx >= N) idx = idx - N;
        if (!found && in_valid[idx]) begin
          found  = 1'b1;
          chosen = SEL_W'(idx);
        end
      end
    end
  end

  // Handshake: only the chosen channel sees ready, and nothing is ready while in reset.
  always_comb begin
    load     = !out_valid || out_ready;
    in_ready = '0;
    if (rst_n && found && load) in_ready[chosen] = 1'b1;
    xfer     = rst_n && found && load && in_valid[chosen];
  end

  // Output register and round-robin pointer; pointer advances only on round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        if (xfer) begin
          out_data  <= ch_data[chosen];
          out_src   <= chosen;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (mode && xfer) begin
        ptr <= (int'(chosen) == N - 1) ? '0 : chosen + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_multiplexer.sv
// Self-checking bench for stream_multiplexer: directed steps plus random traffic vs a queue-free reference model.
// Main instance N=4, WIDTH=64; a second N=3 instance covers the out-of-range select.
// Inputs change 1ns after the rising edge; ready is checked on the falling edge, outputs 1ns after rising.
module tb_stream_multiplexer;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main instance (N=4)
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] d [4];
  logic [255:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;

  assign in_data = {d[3], d[2], d[1], d[0]};

  stream_multiplexer #(.WIDTH(64), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src)
  );

  // Second instance (N=3) for the invalid-select case
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [191:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [63:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_out_src;

  stream_multiplexer #(.WIDTH(64), .N(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_src(b_out_src)
  );

  int passes = 0;
  int total  = 0;

  // Reference model state: what the output register should hold and where round-robin resumes.
  bit          m_vld;
  logic [63:0] m_data;
  int          m_src;
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0;
  endtask

  // Which channel the rules pick right now (ok=0 when none).
  task automatic model_choose(output bit ok, output int ch);
    ok = 0; ch = 0;
    if (!mode) begin
      ok = (int'(sel) < 4);
      ch = int'(sel);
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!ok && in_valid[c]) begin ok = 1; ch = c; end
      end
    end
  endtask

  // One clock: check ready against the model, advance the model at the edge, check outputs.
  task automatic do_cycle(input string tag);
    bit       ok;
    int       ch;
    bit       m_load;
    bit       tr;
    logic [3:0] exp_rdy;
    @(negedge clk);
    model_choose(ok, ch);
    m_load  = !m_vld || out_ready;
    exp_rdy = (ok && m_load) ? (4'b0001 << ch) : 4'b0000;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    tr = ok && m_load && in_valid[ch];
    @(posedge clk);
    if (m_load) begin
      if (tr) begin
        m_vld = 1; m_data = d[ch]; m_src = ch;
      end else begin
        m_vld = 0;
      end
    end
    if (mode && tr) m_ptr = (ch + 1) % 4;
    #1;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_vld));
    chk({tag, "_out_data"}, out_data, m_data);
    chk({tag, "_out_src"}, 64'(out_src), 64'(m_src));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_src"}, 64'(out_src), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    // ---- Reset with every channel valid ----
    rst_n = 1'b0;
    mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 64'(i + 1);
    in_valid = 4'b1111;
    b_mode = 1'b0; b_sel = 2'd0; b_in_data = '0; b_in_valid = 3'b000; b_out_ready = 1'b1;
    model_reset();
    #1 check_reset_outputs("rst_t1");
    @(negedge clk); check_reset_outputs("rst_neg");
    @(posedge clk); #1 check_reset_outputs("rst_pos");
    rst_n = 1'b1;

    // ---- Fixed mode ----
    mode = 1'b0; sel = 2'd1;
    d[0] = 64'd20; d[1] = 64'd40; in_valid = 4'b0011;
    do_cycle("fix_sel1");
    chk("fix_sel1_lit_data", out_data, 64'd40);
    chk("fix_sel1_lit_src", 64'(out_src), 64'd1);
    sel = 2'd0;
    do_cycle("fix_sel0");
    chk("fix_sel0_lit_data", out_data, 64'd20);
    chk("fix_sel0_lit_src", 64'(out_src), 64'd0);

    // ---- Round-robin fairness (pointer must still be 0 after fixed-mode traffic) ----
    mode = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 64'(10 + i);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_cycle("rr_fair");
      chk("rr_fair_lit_data", out_data, 64'(10 + (i % 4)));
    end

    // ---- Skip and wrap: only ch3 and ch0 valid ----
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      do_cycle("rr_skip");
      chk("rr_skip_lit_src", 64'(out_src), (i % 2 == 0) ? 64'd3 : 64'd0);
    end

    // ---- Back-pressure: capture 11 from ch1, then stall 5 cycles ----
    in_valid = 4'b1111;
    do_cycle("bp_load");
    chk("bp_load_lit_data", out_data, 64'd11);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_cycle("bp_stall");
      chk("bp_stall_lit_data", out_data, 64'd11);
      chk("bp_stall_lit_src", 64'(out_src), 64'd1);
    end
    out_ready = 1'b1;
    do_cycle("bp_release");
    chk("bp_release_lit_src", 64'(out_src), 64'd2);
    chk("bp_release_lit_data", out_data, 64'd12);

    // ---- Reset pulse while stalled ----
    out_ready = 1'b0;
    do_cycle("mid_prestall");
    rst_n = 1'b0;
    model_reset();
    #2 check_reset_outputs("mid_rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_cycle("mid_after");
    chk("mid_after_lit_src", 64'(out_src), 64'd0);
    chk("mid_after_lit_data", out_data, 64'd10);

    // ---- Random traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 4; c++) d[c] = {$urandom, $urandom};
      do_cycle("rand");
    end

    // ---- N=3 instance: out-of-range select drains and stops ----
    b_in_data  = {64'd9, 64'd8, 64'd7};
    b_in_valid = 3'b111;
    b_mode = 1'b0; b_sel = 2'd0; b_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("n3_load_valid", 64'(b_out_valid), 64'd1);
    chk("n3_load_data", b_out_data, 64'd7);
    b_sel = 2'd3;
    @(negedge clk);
    chk("n3_sel3_ready_stalled", 64'(b_in_ready), 64'd0);
    chk("n3_sel3_held_valid", 64'(b_out_valid), 64'd1);
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("n3_sel3_ready_open", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    chk("n3_drain_valid", 64'(b_out_valid), 64'd0);
    chk("n3_drain_data_held", b_out_data, 64'd7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
